// File: rtl/i2c_cmd_ctrl.sv
// CPU-bus command front end for the I2C master: queues single-byte commands,
// runs one en/ready handshake per command and captures read bytes for the CPU.
module i2c_cmd_ctrl #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_data,
    output logic        i2c_rw,
    output logic        i2c_en,
    input  logic [7:0]  i2c_data_out,
    input  logic        i2c_ready,
    output logic        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // IDLE: waiting for a command; REQ: en held until master leaves idle;
    // BUSY: waiting for master ready; DONE: capture read byte.
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              rdy_m_q, rdy_s_q;
    logic [15:0]       fifo_q [FIFO_DEPTH];
    logic [15:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              rw_q, rw_d, en_q, en_d;
    logic [7:0]        rxdata_q, rxdata_d;
    logic              rx_valid_q, rx_valid_d;
    logic              ovf_q, ovf_d;
    logic              tmo_err_q, tmo_err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic cmd_wr, stat_wr, rx_rd, full, empty, push, pop, capture, tmo_hit;
    logic [31:0] status;
    logic unused_wdata;

    assign unused_wdata = ^bus_wdata[31:16];

    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        cmd_wr  = bus_we && (bus_addr == 4'h0);
        stat_wr = bus_we && (bus_addr == 4'h4);
        rx_rd   = bus_re && (bus_addr == 4'h8);
        push    = cmd_wr && !full;
        pop     = (state_q == S_IDLE) && !empty && rdy_s_q;
        status  = {19'b0, 5'(count_q), 2'b0, tmo_err_q, ovf_q, rx_valid_q,
                   empty, full, state_q != S_IDLE};
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = bus_wdata[15:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rw_d    = rw_q;
        en_d    = en_q;
        tmo_d   = tmo_q;
        capture = 1'b0;
        tmo_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    {data_d, rw_d, addr_d} = fifo_q[rd_ptr_q];
                    en_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ, S_BUSY: begin
                if (tmo_q == TMO_LAST) begin
                    en_d    = 1'b0;
                    tmo_hit = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    if (tmo_q != '1) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                    // Dropping en as soon as the master leaves idle keeps it from chaining bytes.
                    if (state_q == S_REQ && !rdy_s_q) begin
                        en_d    = 1'b0;
                        state_d = S_BUSY;
                    end else if (state_q == S_BUSY && rdy_s_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                capture = rw_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rxdata_d   = capture ? i2c_data_out : rxdata_q;
        rx_valid_d = rx_valid_q;
        ovf_d      = ovf_q;
        tmo_err_d  = tmo_err_q;
        if (stat_wr && bus_wdata[3]) rx_valid_d = 1'b0;
        if (stat_wr && bus_wdata[4]) ovf_d      = 1'b0;
        if (stat_wr && bus_wdata[5]) tmo_err_d  = 1'b0;
        if (rx_rd)                   rx_valid_d = 1'b0;
        if (capture)                 rx_valid_d = 1'b1;
        if (cmd_wr && full)          ovf_d      = 1'b1;
        if (tmo_hit)                 tmo_err_d  = 1'b1;

        rdata_d = rdata_q;
        if (bus_re) begin
            case (bus_addr)
                4'h4:    rdata_d = status;
                4'h8:    rdata_d = {24'b0, rxdata_q};
                default: rdata_d = 32'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rdy_m_q    <= 1'b0;
            rdy_s_q    <= 1'b0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rw_q       <= 1'b0;
            en_q       <= 1'b0;
            rxdata_q   <= '0;
            rx_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            tmo_err_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_m_q    <= i2c_ready;
            rdy_s_q    <= rdy_m_q;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rw_q       <= rw_d;
            en_q       <= en_d;
            rxdata_q   <= rxdata_d;
            rx_valid_q <= rx_valid_d;
            ovf_q      <= ovf_d;
            tmo_err_q  <= tmo_err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign i2c_addr  = addr_q;
    assign i2c_data  = data_q;
    assign i2c_rw    = rw_q;
    assign i2c_en    = en_q;
    assign bus_rdata = rdata_q;
    assign irq       = rx_valid_q | tmo_err_q;

endmodule

// File: tb/tb_i2c_cmd_ctrl.sv
// Scoreboard bench for i2c_cmd_ctrl: transaction-level master model, command
// and bus-read expectation queues, checked by independent monitors.
`timescale 1ns/1ps
module tb_i2c_cmd_ctrl;
    localparam int DEPTH = 4;
    localparam int TMO   = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data;
    logic        i2c_rw, i2c_en;
    logic [7:0]  i2c_data_out = '0;
    logic        i2c_ready = 1'b1;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata),
        .i2c_addr(i2c_addr), .i2c_data(i2c_data), .i2c_rw(i2c_rw), .i2c_en(i2c_en),
        .i2c_data_out(i2c_data_out), .i2c_ready(i2c_ready), .irq(irq)
    );

    // Reference model state
    logic [15:0] exp_cmd_q [$];
    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    bit          mdl_rxv = 0, mdl_ovf = 0, mdl_to = 0;
    logic [7:0]  mdl_rx = '0;
    int          issued = 0, done_cnt = 0, txn_seen = 0;
    bit          m_auto = 1, m_stall = 0, m_hold = 0, m_busy = 0, m_rw = 0;
    int          m_force = -1;
    logic [7:0]  m_dout;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] st(input bit busy, input int cnt);
        return {19'b0, 5'(cnt), 2'b0, mdl_to, mdl_ovf, mdl_rxv, cnt == 0, cnt == DEPTH, busy};
    endfunction

    function automatic logic [31:0] rand_cmd(input bit rw);
        logic [31:0] c;
        c = $urandom;
        c[31:16] = '0;
        c[7] = rw;
        return c;
    endfunction

    // Transaction monitor: each i2c_en rise must match the oldest accepted command
    logic        en_prev = 1'b0;
    logic [15:0] mon_e;
    always @(negedge clk) begin
        if (rst && i2c_en && !en_prev) begin
            txn_seen++;
            if (exp_cmd_q.size() == 0) begin
                check("unexpected_txn", 32'(i2c_en), 32'd0);
            end else begin
                mon_e = exp_cmd_q.pop_front();
                check("txn", {16'h0, i2c_data, i2c_rw, i2c_addr}, {16'h0, mon_e});
            end
        end
        en_prev = i2c_en;
    end

    // Bus read monitor
    bit rd_pend = 0;
    always @(posedge clk) rd_pend <= bus_re && rst;
    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
            else check(rd_name_q.pop_front(), bus_rdata, rd_exp_q.pop_front());
        end
    end

    // Master model: leaves idle a little after en, stays busy, returns to ready
    always begin
        @(negedge clk);
        if (m_auto && !m_stall && rst && i2c_en && i2c_ready) begin
            m_busy = 1;
            m_rw   = i2c_rw;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            #1 i2c_ready = 1'b0;
            repeat ($urandom_range(4, 9)) @(negedge clk);
            while (m_hold) @(negedge clk);
            #1;
            if (m_rw) begin
                m_dout = (m_force >= 0) ? 8'(m_force) : 8'($urandom);
                i2c_data_out = m_dout;
                mdl_rx  = m_dout;
                mdl_rxv = 1;
            end
            i2c_ready = 1'b1;
            done_cnt++;
            m_busy = 0;
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk); #1;
        if (a == 4'h0) begin
            if (exp_cmd_q.size() < DEPTH) begin
                exp_cmd_q.push_back(d[15:0]);
                issued++;
            end else begin
                mdl_ovf = 1;
            end
        end else if (a == 4'h4) begin
            if (d[3]) mdl_rxv = 0;
            if (d[4]) mdl_ovf = 0;
            if (d[5]) mdl_to  = 0;
        end
        bus_addr = a; bus_wdata = d; bus_we = 1'b1;
        @(negedge clk); #1;
        bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk); #1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        if (a == 4'h8) mdl_rxv = 0;
        bus_addr = a; bus_re = 1'b1;
        @(negedge clk); #1;
        bus_re = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int b = 0;
        while (done_cnt != issued && b < 2000) begin @(negedge clk); b++; end
        check({name, "_done"}, 32'(done_cnt), 32'(issued));
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_en(input string name);
        int b = 0;
        while (!i2c_en && b < 50) begin @(negedge clk); b++; end
        check({name, "_en"}, 32'(i2c_en), 32'd1);
    endtask

    task automatic wait_busy(input string name);
        int b = 0;
        while (!m_busy && b < 50) begin @(negedge clk); b++; end
        check({name, "_busy"}, 32'(m_busy), 32'd1);
    endtask

    // Bench-driven read transaction; overlap=1 lands an RXDATA read on the capture cycle
    task automatic manual_rd(input logic [7:0] v, input bit overlap);
        bus_write(4'h0, {16'h0, 8'h00, 1'b1, 7'h33});
        wait_en("man");
        @(negedge clk); #1 i2c_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("req_hold", 32'(i2c_en), 32'd1);
        @(negedge clk);
        check("req_drop", 32'(i2c_en), 32'd0);
        repeat (2) @(negedge clk);
        #1 i2c_data_out = v; i2c_ready = 1'b1;
        done_cnt++;
        if (overlap) begin
            repeat (2) @(negedge clk);
            bus_read(4'h8, {24'h0, mdl_rx}, "same_cycle_old");
        end
        mdl_rx  = v;
        mdl_rxv = 1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int seen0;
        int b;
        repeat (3) @(negedge clk);
        check("rst_en", 32'(i2c_en), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_outs", 32'({i2c_addr, i2c_data, i2c_rw}), 32'd0);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(4'h4, st(0, 0), "reset_status");

        // Single write command
        bus_write(4'h0, 32'h0000_A550);
        wait_done("wr");
        bus_read(4'h4, st(0, 0), "wr_status");
        check("wr_irq", 32'(irq), 32'd0);

        // Single read command returning 0x3C
        m_force = 'h3C;
        bus_write(4'h0, 32'h0000_00D1);
        wait_done("rd");
        m_force = -1;
        bus_read(4'h4, st(0, 0), "rd_status");
        check("rd_irq", 32'(irq), 32'd1);
        bus_read(4'h8, 32'h0000_003C, "rxdata");
        check("rd_irq_clr", 32'(irq), 32'd0);
        bus_read(4'h4, st(0, 0), "rd_status_clr");

        // Overflow with master held busy
        m_hold = 1;
        bus_write(4'h0, rand_cmd(0));
        wait_busy("ovf");
        repeat (5) bus_write(4'h0, rand_cmd(0));
        bus_read(4'h4, st(1, 4), "ovf_status");
        check("ovf_irq", 32'(irq), 32'd0);
        m_hold = 0;
        wait_done("ovf");
        bus_write(4'h4, 32'h10);
        bus_read(4'h4, st(0, 0), "ovf_clr");

        // Undefined offset
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'hC, 32'h0, "undef_rd");
        bus_read(4'h4, st(0, 0), "undef_status");

        // Timeout: master never leaves idle
        m_stall = 1;
        bus_write(4'h0, {16'h0, 8'h5A, 1'b0, 7'h22});
        wait_en("to");
        repeat (TMO - 1) @(negedge clk);
        check("to_en_hold", 32'(i2c_en), 32'd1);
        @(negedge clk);
        check("to_en_drop", 32'(i2c_en), 32'd0);
        check("to_irq", 32'(irq), 32'd1);
        mdl_to = 1;
        issued--;
        bus_read(4'h4, st(0, 0), "to_status");
        bus_write(4'h4, 32'h20);
        bus_read(4'h4, st(0, 0), "to_clr");
        check("to_irq_clr", 32'(irq), 32'd0);
        m_stall = 0;

        // RXDATA read colliding with capture
        m_auto = 0;
        manual_rd(8'h11, 0);
        manual_rd(8'h77, 1);
        bus_read(4'h4, st(0, 0), "same_cycle_status");
        bus_read(4'h8, 32'h0000_0077, "same_cycle_new");
        bus_read(4'h4, st(0, 0), "same_cycle_clr");
        m_auto = 1;

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            bus_write(4'h0, rand_cmd(1'($urandom)));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_done("rand");
        bus_read(4'h4, st(0, 0), "rand_status");
        if (mdl_rxv) bus_read(4'h8, {24'h0, mdl_rx}, "rand_rxdata");
        bus_write(4'h4, 32'h38);
        bus_read(4'h4, st(0, 0), "rand_clr");

        // Reset in BUSY with two commands queued and rx_valid set
        bus_write(4'h0, rand_cmd(1));
        wait_done("pre_rst");
        m_hold = 1;
        bus_write(4'h0, rand_cmd(0));
        wait_busy("rst");
        repeat (6) @(negedge clk);
        bus_write(4'h0, rand_cmd(0));
        bus_write(4'h0, rand_cmd(0));
        @(negedge clk); #1 rst = 1'b0;
        exp_cmd_q.delete();
        mdl_rxv = 0; mdl_ovf = 0; mdl_to = 0;
        @(negedge clk);
        check("rst_mid_en", 32'(i2c_en), 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        #1 rst = 1'b1;
        m_hold = 0;
        b = 0;
        while (m_busy && b < 50) begin @(negedge clk); b++; end
        check("rst_master_idle", 32'(m_busy), 32'd0);
        issued = done_cnt;
        seen0  = txn_seen;
        repeat (30) @(negedge clk);
        check("rst_no_txn", 32'(txn_seen), 32'(seen0));
        bus_read(4'h4, st(0, 0), "rst_status");
        bus_read(4'h8, 32'h0, "rst_rxdata");
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
